// File: rtl/trace_capture.sv
// trace_capture: arm/trigger/capture trace buffer for a processor debug bus.
//
// After an arm pulse the block waits for tmp_in == TRIG_VALUE. It stores that
// sample and then keeps storing samples until a stop pulse arrives or the
// buffer overflows. A read port pops the oldest entry at any time.
//
// Optional feature macro: TRACE_CHANGE_ONLY_EN.
//   Defined   - in CAPTURE a sample is stored only when it differs from the
//               last stored sample. The trigger sample is always stored.
//   Undefined - in CAPTURE every cycle's sample is stored.
//
// Handshake: rd_req is a level request. It pops only when empty=0. The
// popped value appears on rd_data one cycle later, and rd_valid is high for
// exactly that one cycle. Nothing back-pressures rd_req.
module trace_capture #(
    parameter int DEPTH      = 16,
    parameter int WIDTH      = 5,
    parameter int TRIG_VALUE = 0
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [WIDTH-1:0]           tmp_in,
    input  logic                       arm,
    input  logic                       stop,
    input  logic                       rd_req,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [1:0]                 state
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam logic [WIDTH-1:0] TRIG    = TRIG_VALUE[WIDTH-1:0];
    localparam logic [CW-1:0]    FULL_CT = CW'(DEPTH);

    logic [1:0]       state_q, state_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             empty_w;
    logic             full_w;
    logic             pop;
    logic             wr_en;
    logic             clear;
    logic             want_cap;

    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == FULL_CT);

    // An arm pulse flushes the buffer, so a pop on that same cycle is dropped.
    assign pop = rd_req && !empty_w && !arm;

`ifdef TRACE_CHANGE_ONLY_EN
    logic [WIDTH-1:0] last_q;

    // Remember the most recently stored sample so repeats can be skipped.
    always_ff @(posedge CLK) begin
        if (RST) begin
            last_q <= '0;
        end else if (wr_en) begin
            last_q <= tmp_in;
        end
    end

    assign want_cap = (tmp_in != last_q);
`else
    assign want_cap = 1'b1;
`endif

    // FSM and write decision. Arm has priority over stop and trigger. A full
    // buffer accepts a write only when a pop frees a slot on the same cycle.
    always_comb begin
        state_d    = state_q;
        overflow_d = overflow_q;
        wr_en      = 1'b0;
        clear      = 1'b0;
        if (arm) begin
            state_d    = ST_ARMED;
            overflow_d = 1'b0;
            clear      = 1'b1;
        end else begin
            case (state_q)
                ST_ARMED: begin
                    if (tmp_in == TRIG) begin
                        wr_en   = !full_w || pop;
                        state_d = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (stop) begin
                        state_d = ST_DONE;
                    end else if (want_cap) begin
                        if (!full_w || pop) begin
                            wr_en = 1'b1;
                        end else begin
                            overflow_d = 1'b1;
                            state_d    = ST_DONE;
                        end
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // Pointer and occupancy bookkeeping. Pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({wr_en, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Registered read port: data holds its value when no pop happens.
    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = pop;
        if (pop) begin
            rd_data_d = mem_q[rd_ptr_q];
        end
    end

    // Control and status registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Sample storage. The contents are not reset; occupancy tracking makes
    // stale entries unreachable.
    always_ff @(posedge CLK) begin
        if (!RST && wr_en) begin
            mem_q[wr_ptr_q] <= tmp_in;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign empty    = empty_w;
    assign full     = full_w;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign state    = state_q;

endmodule

// File: tb/tb_trace_capture.sv
// tb_trace_capture: table-driven bench for trace_capture (DEPTH=4, WIDTH=5,
// TRIG_VALUE=3), plus hand sequences for the capture-filter behaviour.
module tb_trace_capture;

    localparam int DEPTH = 4;
    localparam int WIDTH = 5;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             CLK = 1'b0;
    logic             RST;
    logic [WIDTH-1:0] tmp_in;
    logic             arm;
    logic             stop;
    logic             rd_req;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             empty;
    logic             full;
    logic [CW-1:0]    count;
    logic             overflow;
    logic [1:0]       state;

    int checks = 0;
    int errors = 0;

    trace_capture #(.DEPTH(DEPTH), .WIDTH(WIDTH), .TRIG_VALUE(3)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .tmp_in   (tmp_in),
        .arm      (arm),
        .stop     (stop),
        .rd_req   (rd_req),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow),
        .state    (state)
    );

    // clock
    always #5 CLK = ~CLK;

    typedef struct {
        logic             rst;
        logic             arm;
        logic             stop;
        logic             rd;
        logic [WIDTH-1:0] tmp;
        logic [1:0]       st;
        logic [CW-1:0]    cnt;
        logic             emp;
        logic             ful;
        logic             ovf;
        logic             rv;
        logic             chk_rd;
        logic [WIDTH-1:0] rdd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic a, input logic s,
                                input logic rd, input logic [WIDTH-1:0] tmp,
                                input logic [1:0] st, input logic [CW-1:0] cnt,
                                input logic emp, input logic ful, input logic ovf,
                                input logic rv, input logic chk, input logic [WIDTH-1:0] rdd);
        vec_t v;
        v.rst = rst; v.arm = a; v.stop = s; v.rd = rd; v.tmp = tmp;
        v.st = st; v.cnt = cnt; v.emp = emp; v.ful = ful; v.ovf = ovf;
        v.rv = rv; v.chk_rd = chk; v.rdd = rdd;
        return v;
    endfunction

    task automatic check(input string name, input int row, input logic [31:0] got,
                         input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s row %0d: got %0h want %0h", name, row, got, want);
        end
    endtask

    // Drive one cycle of inputs, then sample outputs 1 time unit after the edge.
    task automatic step(input logic r, input logic a, input logic s, input logic rd,
                        input logic [WIDTH-1:0] t);
        RST = r; arm = a; stop = s; rd_req = rd; tmp_in = t;
        @(posedge CLK);
        #1;
    endtask

    task automatic pop_expect(input int row, input logic [WIDTH-1:0] want);
        step(0, 0, 0, 1, 0);
        check("pop_valid", row, 32'(rd_valid), 32'd1);
        check("pop_data", row, 32'(rd_data), 32'(want));
    endtask

    initial begin
        RST = 1'b1; arm = 0; stop = 0; rd_req = 0; tmp_in = '0;
        // rst arm stop rd tmp | state cnt empty full ovf rv chk_rd rd_data
        vecs.push_back(mk(1,0,0,0, 0, 0,0,1,0,0,0,1, 0));   // reset
        vecs.push_back(mk(0,0,0,0, 5, 0,0,1,0,0,0,1, 0));   // idle, no write
        vecs.push_back(mk(0,0,0,1, 5, 0,0,1,0,0,0,1, 0));   // read while empty
        vecs.push_back(mk(0,1,0,0, 5, 1,0,1,0,0,0,1, 0));   // arm
        vecs.push_back(mk(0,0,0,0, 1, 1,0,1,0,0,0,0, 0));
        vecs.push_back(mk(0,0,0,0, 2, 1,0,1,0,0,0,0, 0));
        vecs.push_back(mk(0,0,0,0, 3, 2,1,0,0,0,0,0, 0));   // trigger write
        vecs.push_back(mk(0,0,0,0, 4, 2,2,0,0,0,0,0, 0));
        vecs.push_back(mk(0,0,0,0, 5, 2,3,0,0,0,0,0, 0));
        vecs.push_back(mk(0,0,1,0, 9, 3,3,0,0,0,0,0, 0));   // stop, no write
        vecs.push_back(mk(0,0,0,1, 9, 3,2,0,0,0,1,1, 3));
        vecs.push_back(mk(0,0,0,1, 9, 3,1,0,0,0,1,1, 4));
        vecs.push_back(mk(0,0,0,1, 9, 3,0,1,0,0,1,1, 5));
        vecs.push_back(mk(0,0,0,1, 9, 3,0,1,0,0,0,1, 5));   // empty read, data held
        vecs.push_back(mk(0,1,0,0, 3, 1,0,1,0,0,0,0, 0));   // arm beats trigger
        vecs.push_back(mk(0,0,0,0, 3, 2,1,0,0,0,0,0, 0));
        vecs.push_back(mk(0,0,0,0,10, 2,2,0,0,0,0,0, 0));
        vecs.push_back(mk(0,0,0,0,11, 2,3,0,0,0,0,0, 0));
        vecs.push_back(mk(0,0,0,0,12, 2,4,0,1,0,0,0, 0));   // full
        vecs.push_back(mk(0,0,0,0,13, 3,4,0,1,1,0,0, 0));   // dropped -> DONE
        vecs.push_back(mk(0,0,0,0,14, 3,4,0,1,1,0,0, 0));
        vecs.push_back(mk(0,1,0,0, 0, 1,0,1,0,0,0,0, 0));   // arm clears overflow
        vecs.push_back(mk(0,0,0,0, 3, 2,1,0,0,0,0,0, 0));
        vecs.push_back(mk(0,0,0,0,20, 2,2,0,0,0,0,0, 0));
        vecs.push_back(mk(0,0,0,0,21, 2,3,0,0,0,0,0, 0));
        vecs.push_back(mk(0,0,0,0,22, 2,4,0,1,0,0,0, 0));
        vecs.push_back(mk(0,0,0,1,23, 2,4,0,1,0,1,1, 3));   // write+read at full
        vecs.push_back(mk(0,0,0,1,24, 2,4,0,1,0,1,1,20));
        vecs.push_back(mk(0,0,1,1,25, 3,3,0,0,0,1,1,21));   // stop with read
        vecs.push_back(mk(0,0,0,1, 0, 3,2,0,0,0,1,1,22));
        vecs.push_back(mk(0,0,0,1, 0, 3,1,0,0,0,1,1,23));
        vecs.push_back(mk(0,0,0,1, 0, 3,0,1,0,0,1,1,24));   // wrapped pointers
        vecs.push_back(mk(0,1,1,0, 0, 1,0,1,0,0,0,0, 0));   // arm beats stop
        vecs.push_back(mk(0,0,0,0, 3, 2,1,0,0,0,0,0, 0));
        vecs.push_back(mk(0,0,0,1, 6, 2,1,0,0,0,1,1, 3));
        vecs.push_back(mk(1,0,0,1, 7, 0,0,1,0,0,0,1, 0));   // reset mid-capture
        vecs.push_back(mk(0,0,0,1, 7, 0,0,1,0,0,0,1, 0));
        vecs.push_back(mk(0,1,0,0, 0, 1,0,1,0,0,0,0, 0));
        vecs.push_back(mk(1,1,0,0, 3, 0,0,1,0,0,0,1, 0));   // reset beats arm

        @(negedge CLK);
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].arm, vecs[i].stop, vecs[i].rd, vecs[i].tmp);
            check("state", i, 32'(state), 32'(vecs[i].st));
            check("count", i, 32'(count), 32'(vecs[i].cnt));
            check("empty", i, 32'(empty), 32'(vecs[i].emp));
            check("full", i, 32'(full), 32'(vecs[i].ful));
            check("overflow", i, 32'(overflow), 32'(vecs[i].ovf));
            check("rd_valid", i, 32'(rd_valid), 32'(vecs[i].rv));
            if (vecs[i].chk_rd) begin
                check("rd_data", i, 32'(rd_data), 32'(vecs[i].rdd));
            end
        end

        // Capture filter: repeated samples after the trigger.
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 3);
        step(0, 0, 0, 0, 3);
        step(0, 0, 0, 0, 7);
        step(0, 0, 0, 0, 7);
        step(0, 0, 0, 0, 2);
        step(0, 0, 1, 0, 2);
        check("seq_state", 100, 32'(state), 32'd3);
`ifdef TRACE_CHANGE_ONLY_EN
        check("seq_count", 100, 32'(count), 32'd3);
        pop_expect(101, 3);
        pop_expect(102, 7);
        pop_expect(103, 2);
`else
        check("seq_count", 100, 32'(count), 32'd4);
        pop_expect(101, 3);
        pop_expect(102, 3);
        pop_expect(103, 7);
        pop_expect(104, 7);
`endif
        check("seq_empty", 105, 32'(empty), 32'd1);
        step(0, 0, 0, 1, 0);
        check("seq_no_valid", 106, 32'(rd_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trace_capture.md
TRACE_CAPTURE -- requirements
Module: trace_capture

Interface
REQ-001 Parameter DEPTH, default 16, buffer entries (power of two, 4..64).
REQ-002 Parameter WIDTH, default 5, sample width, matching the processor debug output tmp.
REQ-003 Parameter TRIG_VALUE, default 0, sample value that starts capture.
REQ-004 CLK  input  1  single clock, all state updates on rising edge.
REQ-005 RST  input  1  reset, synchronous, active-high.
REQ-006 tmp_in  input  WIDTH  processor debug output, sampled every cycle.
REQ-007 arm  input  1  one-cycle pulse; clears buffer, enters ARMED.
REQ-008 stop  input  1  one-cycle pulse; ends capture.
REQ-009 rd_req  input  1  read request for the oldest entry.
REQ-010 rd_data  output  WIDTH  read data, registered.
REQ-011 rd_valid  output  1  one-cycle pulse qualifying rd_data.
REQ-012 empty  output  1  buffer holds zero entries.
REQ-013 full  output  1  buffer holds DEPTH entries.
REQ-014 count  output  clog2(DEPTH)+1  current entry count.
REQ-015 overflow  output  1  sticky flag: a sample was dropped.
REQ-016 state  output  2  FSM state: IDLE=0, ARMED=1, CAPTURE=2, DONE=3.

Function
REQ-017 IDLE: no writes; arm -> ARMED.
REQ-018 ARMED: when tmp_in == TRIG_VALUE, write that sample and go to CAPTURE in the same edge.
REQ-019 CAPTURE: write tmp_in every cycle, subject to REQ-029 when the macro is defined.
REQ-020 CAPTURE: stop -> DONE; no write on the stop cycle.
REQ-021 DONE: no writes; arm -> ARMED.
REQ-022 arm in any state clears count, pointers and overflow, and sets state to ARMED; arm takes priority over stop and trigger.
REQ-023 Read: rd_req with empty=0 pops the oldest entry; rd_data holds it and rd_valid=1 on the next cycle.
REQ-024 rd_req with empty=1 is ignored: rd_valid=0, rd_data unchanged.
REQ-025 Reads are legal in every state.
REQ-026 Simultaneous write and read: both occur and count is unchanged, including when full.
REQ-027 Full in CAPTURE with no pop the same cycle: sample dropped, overflow=1, state -> DONE.
REQ-028 Pointers wrap modulo DEPTH; count never exceeds DEPTH or goes below 0.

Configuration
REQ-029 Macro TRACE_CHANGE_ONLY_EN. Defined: in CAPTURE, write only when tmp_in differs from the last written sample. Undefined: write every CAPTURE cycle. The trigger write in ARMED always occurs.

Reset
REQ-030 RST=1 at a rising edge forces state=IDLE, count=0, pointers=0, empty=1, full=0, overflow=0, rd_valid=0, rd_data=0.
REQ-031 RST overrides arm, stop and rd_req in the same cycle; buffer contents are don't-care after reset.
REQ-032 RST asserted mid-capture discards all entries; no rd_valid is produced the cycle after reset.

Verification
REQ-033 RST 1 cycle, then idle -> state=0, empty=1, count=0, rd_valid=0.
REQ-034 TRIG_VALUE=3; arm; tmp_in 1,2,3,4,5 then stop -> state=3, count=3; three pops return 3,4,5, then empty=1.
REQ-035 DEPTH=4; arm; trigger; hold CAPTURE 6 cycles, no reads -> full=1, overflow=1, state=3, count=4.
REQ-036 Full, then rd_req together with a CAPTURE write -> count stays 4, overflow=0, oldest value returned.
REQ-037 rd_req while empty -> rd_valid=0 and rd_data unchanged.
REQ-038 With TRACE_CHANGE_ONLY_EN: after trigger 0, tmp_in 0,0,7,7,2 then stop -> entries 0,7,2, count=3.
